cmult_scheduler: RTL and testbench

Sequenced signed complex multiplier built around one shared W×W real multiplier. It takes one operand pair per transaction on an ie/in_rdy handshake. A state machine then time-multiplexes the four partial products through the multiplier and add/sub stage, and the result is presented on an out_vld/out_rdy handshake. It is the multi-bit, flow-controlled successor to the single-bit complex multiplier top level and sits between an operand source and a result consumer.

---
 rtl/cmult_scheduler.sv | 134 +++++++++++++
 tb/tb_cmult_scheduler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cmult_scheduler.sv
// Sequenced signed complex multiplier: one shared WxW multiplier walks the four
// partial products over four cycles, result held on an out_vld/out_rdy handshake.
module cmult_scheduler #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ie,
  output logic                in_rdy,
  input  logic                conj,
  input  logic signed [W-1:0] a_r,
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_r,
  input  logic signed [W-1:0] b_i,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic signed [2*W:0] p_r,
  output logic signed [2*W:0] p_i,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_MRR, S_MII, S_MRI, S_MIR, S_SUM, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     ar_q, ai_q, br_q, bi_q;
  logic             conj_q;
  logic [2*W-1:0]   pp1_q, pp1_d, pp2_q, pp2_d;
  logic [2*W:0]     pr_q, pr_d, pi_q, pi_d;
  logic             vld_q, vld_d;
  logic             accept;

  logic [W-1:0]     mx, my;
  logic [2*W-1:0]   prod;
  logic [2*W:0]     pp1_x, pp2_x, sum_r, sum_i;

  assign accept = (state_q == S_IDLE) && ie;

  // Operand select for the single shared multiplier, keyed by state.
  always_comb begin
    mx = ar_q;
    my = br_q;
    case (state_q)
      S_MII:   begin mx = ai_q; my = bi_q; end
      S_MRI:   begin mx = ar_q; my = bi_q; end
      S_MIR:   begin mx = ai_q; my = br_q; end
      default: begin mx = ar_q; my = br_q; end
    endcase
  end

  // Low 2W bits of the product of sign-extended operands are the signed product.
  assign prod  = {{W{mx[W-1]}}, mx} * {{W{my[W-1]}}, my};
  assign pp1_x = {pp1_q[2*W-1], pp1_q};
  assign pp2_x = {pp2_q[2*W-1], pp2_q};
  assign sum_r = conj_q ? (pp1_x + pp2_x) : (pp1_x - pp2_x);
  assign sum_i = conj_q ? (pp2_x - pp1_x) : (pp1_x + pp2_x);

  always_comb begin
    state_d = state_q;
    pp1_d   = pp1_q;
    pp2_d   = pp2_q;
    pr_d    = pr_q;
    pi_d    = pi_q;
    vld_d   = vld_q;
    case (state_q)
      S_IDLE: if (ie) state_d = S_MRR;
      S_MRR: begin
        pp1_d   = prod;
        state_d = S_MII;
      end
      S_MII: begin
        pp2_d   = prod;
        state_d = S_MRI;
      end
      S_MRI: begin
        pr_d    = sum_r;
        pp1_d   = prod;
        state_d = S_MIR;
      end
      S_MIR: begin
        pp2_d   = prod;
        state_d = S_SUM;
      end
      S_SUM: begin
        pi_d    = sum_i;
        vld_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: if (out_rdy) begin
        vld_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ar_q    <= '0;
      ai_q    <= '0;
      br_q    <= '0;
      bi_q    <= '0;
      conj_q  <= 1'b0;
      pp1_q   <= '0;
      pp2_q   <= '0;
      pr_q    <= '0;
      pi_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pp1_q   <= pp1_d;
      pp2_q   <= pp2_d;
      pr_q    <= pr_d;
      pi_q    <= pi_d;
      vld_q   <= vld_d;
      if (accept) begin
        ar_q   <= a_r;
        ai_q   <= a_i;
        br_q   <= b_r;
        bi_q   <= b_i;
        conj_q <= conj;
      end
    end
  end

  assign in_rdy  = (state_q == S_IDLE) && !rst;
  assign busy    = (state_q != S_IDLE);
  assign out_vld = vld_q;
  assign p_r     = pr_q;
  assign p_i     = pi_q;

endmodule

// File: tb/tb_cmult_scheduler.sv
// Directed bench for cmult_scheduler (W=8): arithmetic, latency, backpressure,
// continuous ie, and mid-transaction reset.
module tb_cmult_scheduler;
  localparam int W = 8;

  logic                clk = 1'b0;
  logic                rst, ie, conj, out_rdy;
  logic signed [W-1:0] a_r, a_i, b_r, b_i;
  logic                in_rdy, out_vld, busy;
  logic signed [2*W:0] p_r, p_i;

  int n_chk  = 0;
  int n_pass = 0;

  cmult_scheduler #(.W(W)) dut (
    .clk(clk), .rst(rst), .ie(ie), .in_rdy(in_rdy), .conj(conj),
    .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i),
    .out_vld(out_vld), .out_rdy(out_rdy), .p_r(p_r), .p_i(p_i), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int ex_r(input logic cj, input int ar, ai, br, bi);
    return cj ? (ar*br + ai*bi) : (ar*br - ai*bi);
  endfunction

  function automatic int ex_i(input logic cj, input int ar, ai, br, bi);
    return cj ? (ai*br - ar*bi) : (ar*bi + ai*br);
  endfunction

  // Accept one transaction, scramble live inputs, wait for out_vld and check it.
  task automatic txn(input string tag, input logic cj, input int ar, ai, br, bi,
                     input int epr, input int epi);
    int lat;
    conj = cj; a_r = W'(ar); a_i = W'(ai); b_r = W'(br); b_i = W'(bi);
    ie = 1'b1;
    chk({tag, "_in_rdy_pre"}, in_rdy, 1);
    tick();
    ie = 1'b0;
    a_r = W'($urandom); a_i = W'($urandom); b_r = W'($urandom); b_i = W'($urandom);
    conj = ~cj;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_in_rdy_busy"}, in_rdy, 0);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_vld && lat < 20);
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_p_r"}, p_r, epr);
    chk({tag, "_p_i"}, p_i, epi);
  endtask

  // Handshake edge with out_rdy high: back to idle, one-cycle out_vld.
  task automatic finish_hs(input string tag);
    out_rdy = 1'b1;
    tick();
    chk({tag, "_vld_drop"}, out_vld, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_rdy"}, in_rdy, 1);
  endtask

  initial begin
    logic ok;
    rst = 1'b1; ie = 1'b0; conj = 1'b0; out_rdy = 1'b1;
    a_r = '0; a_i = '0; b_r = '0; b_i = '0;
    tick(); tick();
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_p_r", p_r, 0);
    chk("rst_p_i", p_i, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_rdy", in_rdy, 1);
    tick();

    txn("c0", 1'b0, 3, 4, 5, 6, -9, 38);
    finish_hs("c0");
    txn("c1", 1'b1, 3, 4, 5, 6, 39, 2);
    finish_hs("c1");
    txn("min", 1'b0, -128, -128, -128, -128, 0, 32768);
    finish_hs("min");
    txn("mix", 1'b0, -128, -128, -128, 127, 32640, 128);
    finish_hs("mix");

    // Backpressure: DONE holds, ie pulses ignored.
    out_rdy = 1'b0;
    txn("bp", 1'b0, 2, 1, 1, 1, 1, 3);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ie = i[0];
      a_r = W'($urandom); b_i = W'($urandom);
      tick();
      if (out_vld !== 1'b1 || p_r !== 17'sd1 || p_i !== 17'sd3 ||
          in_rdy !== 1'b0 || busy !== 1'b1) ok = 1'b0;
    end
    ie = 1'b0;
    chk("bp_stable", ok, 1);
    finish_hs("bp");
    chk("bp_keep_p_r", p_r, 1);
    chk("bp_keep_p_i", p_i, 3);
    txn("bp_next", 1'b0, 1, 0, 0, 1, 0, 1);
    finish_hs("bp_next");

    // ie held high, operands change every cycle; accepts on a 7-edge cadence.
    for (int t = 0; t < 21; t++) begin
      a_r = W'(t + 1); a_i = W'(-(t + 2)); b_r = W'(3*t - 5); b_i = W'(7 - t);
      conj = t[0];
      ie = 1'b1;
      tick();
      chk($sformatf("cont_vld_%0d", t), out_vld, (t % 7 == 5) ? 1 : 0);
      if (t % 7 == 5) begin
        chk($sformatf("cont_pr_%0d", t), p_r,
            ex_r(((t-5) % 2) == 1, t-4, -(t-3), 3*(t-5)-5, 7-(t-5)));
        chk($sformatf("cont_pi_%0d", t), p_i,
            ex_i(((t-5) % 2) == 1, t-4, -(t-3), 3*(t-5)-5, 7-(t-5)));
      end
    end
    ie = 1'b0;
    tick();
    chk("cont_end_idle", in_rdy, 1);

    // Reset while in MIR discards the transaction.
    conj = 1'b0; a_r = 8'sd9; a_i = 8'sd7; b_r = 8'sd5; b_i = 8'sd3;
    ie = 1'b1;
    tick();
    ie = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("mrst_vld", out_vld, 0);
    chk("mrst_p_r", p_r, 0);
    chk("mrst_p_i", p_i, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_in_rdy_hi", in_rdy, 0);
    rst = 1'b0;
    #1;
    chk("mrst_in_rdy_rel", in_rdy, 1);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_vld !== 1'b0) ok = 1'b0;
    end
    chk("mrst_no_vld", ok, 1);
    txn("post", 1'b1, -7, 11, 13, -2, ex_r(1'b1, -7, 11, 13, -2), ex_i(1'b1, -7, 11, 13, -2));
    finish_hs("post");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
